// File: rtl/gx400_video_pkg.sv
// Shared definitions for the GX400 video memory path: default bus widths,
// CPU-port state encoding and a counter-width helper.
package gx400_video_pkg;

  localparam int unsigned GX_AW = 10;
  localparam int unsigned GX_DW = 8;

  typedef enum logic [2:0] {
    C_IDLE = 3'd0,
    C_WAIT = 3'd1,
    C_WR   = 3'd2,
    C_RD1  = 3'd3,
    C_RD2  = 3'd4,
    C_END  = 3'd5
  } cpu_state_e;

  // Bits needed to hold 0..maxv; never returns zero.
  function automatic int unsigned cnt_width(input int unsigned maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/gx400_vram_starve_cnt.sv
// Saturating count of CPU wait cycles; raises o_starve once the count
// reaches MAXWAIT and drops it when the wait is cleared.
module gx400_vram_starve_cnt
  import gx400_video_pkg::*;
#(
  parameter int unsigned MAXWAIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_starve
);

  localparam int unsigned CW = cnt_width(MAXWAIT);
  localparam logic [CW-1:0] CMAX = CW'(MAXWAIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve_q, starve_d;

  always_comb begin
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (i_clr) begin
      cnt_d    = '0;
      starve_d = 1'b0;
    end else begin
      if (i_inc && (cnt_q != CMAX)) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CMAX) starve_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign o_starve = starve_q;

endmodule

// File: rtl/gx400_vram_arbiter.sv
// Single-port VRAM arbiter: video reads take absolute priority, CPU accesses
// fill free cycles. Optional posted write buffer: GX400_VRAM_WRBUF_EN.
module gx400_vram_arbiter
  import gx400_video_pkg::*;
#(
  parameter int unsigned AW      = GX_AW,
  parameter int unsigned DW      = GX_DW,
  parameter int unsigned MAXWAIT = 255
) (
  input  logic          i_MCLK,
  input  logic          i_RST_n,
  input  logic          i_VID_REQ,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [DW-1:0] o_VID_DATA,
  output logic          o_VID_VALID,
  input  logic          i_CPU_REQ,
  input  logic          i_CPU_WR,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_ACK,
  output logic          o_CPU_STARVE,
  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  output logic          o_SRAM_WR_n,
  output logic          o_SRAM_RD_n,
  input  logic [DW-1:0] i_SRAM_DOUT
);

  cpu_state_e    cpu_state_q, cpu_state_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] sram_din_q, sram_din_d;
  logic          sram_wr_n_q, sram_wr_n_d;
  logic          sram_rd_n_q, sram_rd_n_d;
  logic [1:0]    vid_pipe_q, vid_pipe_d;
  logic          vid_valid_q, vid_valid_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic          wait_inc, wait_clr;

`ifdef GX400_VRAM_WRBUF_EN
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
`endif

  always_comb begin
    cpu_state_d = cpu_state_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    sram_wr_n_d = 1'b1;
    sram_rd_n_d = 1'b1;
    cpu_ack_d   = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    // SRAM data appears one cycle after the strobe; capture it one more later.
    vid_pipe_d  = {vid_pipe_q[0], i_VID_REQ};
    vid_valid_d = vid_pipe_q[1];
    vid_data_d  = vid_pipe_q[1] ? i_SRAM_DOUT : vid_data_q;
`ifdef GX400_VRAM_WRBUF_EN
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
`endif

    if (i_VID_REQ) begin
      sram_addr_d = i_VID_ADDR;
      sram_rd_n_d = 1'b0;
    end
`ifdef GX400_VRAM_WRBUF_EN
    else if (wb_valid_q) begin
      sram_addr_d = wb_addr_q;
      sram_din_d  = wb_data_q;
      sram_wr_n_d = 1'b0;
      wb_valid_d  = 1'b0;
    end
`endif

    unique case (cpu_state_q)
      C_IDLE, C_WAIT: begin
        if (!i_CPU_REQ) begin
          cpu_state_d = C_IDLE;
        end
`ifdef GX400_VRAM_WRBUF_EN
        // A pending posted write blocks every CPU access so reads see it.
        else if (wb_valid_q) begin
          cpu_state_d = C_WAIT;
        end else if (i_CPU_WR && i_VID_REQ) begin
          wb_valid_d  = 1'b1;
          wb_addr_d   = i_CPU_ADDR;
          wb_data_d   = i_CPU_DIN;
          cpu_state_d = C_WR;
        end
`endif
        else if (i_VID_REQ) begin
          cpu_state_d = C_WAIT;
        end else begin
          sram_addr_d = i_CPU_ADDR;
          if (i_CPU_WR) begin
            sram_din_d  = i_CPU_DIN;
            sram_wr_n_d = 1'b0;
            cpu_state_d = C_WR;
          end else begin
            sram_rd_n_d = 1'b0;
            cpu_state_d = C_RD1;
          end
        end
      end
      C_WR: begin
        cpu_ack_d   = 1'b1;
        cpu_state_d = C_END;
      end
      C_RD1: cpu_state_d = C_RD2;
      C_RD2: begin
        cpu_dout_d  = i_SRAM_DOUT;
        cpu_ack_d   = 1'b1;
        cpu_state_d = C_END;
      end
      C_END: if (!i_CPU_REQ) cpu_state_d = C_IDLE;
      default: cpu_state_d = C_IDLE;
    endcase

    wait_inc = (cpu_state_q == C_WAIT) && (cpu_state_d == C_WAIT);
    wait_clr = (cpu_state_d != C_WAIT);
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cpu_state_q <= C_IDLE;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      sram_wr_n_q <= 1'b1;
      sram_rd_n_q <= 1'b1;
      vid_pipe_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_dout_q  <= '0;
    end else begin
      cpu_state_q <= cpu_state_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      sram_wr_n_q <= sram_wr_n_d;
      sram_rd_n_q <= sram_rd_n_d;
      vid_pipe_q  <= vid_pipe_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_dout_q  <= cpu_dout_d;
    end
  end

`ifdef GX400_VRAM_WRBUF_EN
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end
`endif

  gx400_vram_starve_cnt #(
    .MAXWAIT (MAXWAIT)
  ) u_starve (
    .i_clk    (i_MCLK),
    .i_rst_n  (i_RST_n),
    .i_inc    (wait_inc),
    .i_clr    (wait_clr),
    .o_starve (o_CPU_STARVE)
  );

  assign o_SRAM_ADDR = sram_addr_q;
  assign o_SRAM_DIN  = sram_din_q;
  assign o_SRAM_WR_n = sram_wr_n_q;
  assign o_SRAM_RD_n = sram_rd_n_q;
  assign o_VID_VALID = vid_valid_q;
  assign o_VID_DATA  = vid_data_q;
  assign o_CPU_ACK   = cpu_ack_q;
  assign o_CPU_DOUT  = cpu_dout_q;

endmodule

// File: tb/tb_gx400_vram_arbiter.sv
// Bench for gx400_vram_arbiter: SRAM model, transaction-level reference model
// compared every cycle, directed scenarios and a randomized traffic phase.
module tb_gx400_vram_arbiter;
  import gx400_video_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned MAXWAIT = 4;
`ifdef GX400_VRAM_WRBUF_EN
  localparam bit WRBUF = 1'b1;
`else
  localparam bit WRBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          cpu_req = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] o_VID_DATA, o_CPU_DOUT, o_SRAM_DIN;
  logic          o_VID_VALID, o_CPU_ACK, o_CPU_STARVE, o_SRAM_WR_n, o_SRAM_RD_n;
  logic [AW-1:0] o_SRAM_ADDR;
  logic [DW-1:0] sram_dout = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gx400_vram_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
    .i_MCLK(clk), .i_RST_n(rst_n),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr),
    .o_VID_DATA(o_VID_DATA), .o_VID_VALID(o_VID_VALID),
    .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_DOUT(o_CPU_DOUT), .o_CPU_ACK(o_CPU_ACK), .o_CPU_STARVE(o_CPU_STARVE),
    .o_SRAM_ADDR(o_SRAM_ADDR), .o_SRAM_DIN(o_SRAM_DIN),
    .o_SRAM_WR_n(o_SRAM_WR_n), .o_SRAM_RD_n(o_SRAM_RD_n),
    .i_SRAM_DOUT(sram_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(input int unsigned i);
    if (i >= 16 && i <= 19) return DW'(8'hA0 + i - 16);
    return DW'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Synchronous SRAM: strobes sampled at the edge, read data registered.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= mem_init(i);
      mem_init_done <= 1'b1;
    end else begin
      if (!o_SRAM_WR_n) mem[o_SRAM_ADDR] <= o_SRAM_DIN;
      if (!o_SRAM_RD_n) sram_dout <= mem[o_SRAM_ADDR];
    end
  end

  // Reference model: tracks memory contents and outstanding transactions.
  typedef struct { int unsigned cyc; logic [DW-1:0] data; } vev_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            ref_init_done = 1'b0;
  vev_t          vq[$];
  int unsigned   mcyc, ack_cyc, wcnt;
  bit            busy, held, waiting, wb_full, ack_rd, wb_pre;
  logic [DW-1:0] ack_data, wb_data;
  logic [AW-1:0] wb_addr;
  logic          e_rd_n, e_wr_n, e_vvalid, e_ack, e_starve;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_vdata, e_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!ref_init_done) begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem_init(i);
        ref_init_done = 1'b1;
      end
      busy = 0; held = 0; waiting = 0; wb_full = 0; wcnt = 0; mcyc = 0;
      vq.delete();
      e_rd_n = 1; e_wr_n = 1; e_addr = '0; e_din = '0;
      e_vvalid = 0; e_vdata = '0; e_ack = 0; e_dout = '0; e_starve = 0;
    end else begin
      mcyc++;
      wb_pre = wb_full;
      e_rd_n = 1; e_wr_n = 1; e_ack = 0; e_vvalid = 0;
      if (vid_req) begin
        e_rd_n = 0; e_addr = vid_addr;
        vq.push_back('{mcyc + 2, ref_mem[vid_addr]});
      end else if (wb_pre) begin
        e_wr_n = 0; e_addr = wb_addr; e_din = wb_data;
        ref_mem[wb_addr] = wb_data; wb_full = 0;
      end
      if (vq.size() > 0 && vq[0].cyc == mcyc) begin
        e_vvalid = 1; e_vdata = vq[0].data;
        void'(vq.pop_front());
      end
      if (busy) begin
        if (mcyc == ack_cyc) begin
          e_ack = 1; if (ack_rd) e_dout = ack_data;
          busy = 0; held = 1;
        end
      end else if (held) begin
        if (!cpu_req) held = 0;
      end else if (!cpu_req) begin
        waiting = 0; wcnt = 0;
      end else if (wb_pre || (vid_req && !(WRBUF && cpu_wr))) begin
        if (waiting) begin
          if (wcnt < MAXWAIT) wcnt++;
        end else begin
          waiting = 1; wcnt = 0;
        end
      end else begin
        waiting = 0; wcnt = 0; busy = 1;
        if (cpu_wr && vid_req) begin
          wb_full = 1; wb_addr = cpu_addr; wb_data = cpu_din;
          ack_rd = 0; ack_cyc = mcyc + 1;
        end else if (cpu_wr) begin
          e_wr_n = 0; e_addr = cpu_addr; e_din = cpu_din;
          ref_mem[cpu_addr] = cpu_din;
          ack_rd = 0; ack_cyc = mcyc + 1;
        end else begin
          e_rd_n = 0; e_addr = cpu_addr;
          ack_data = ref_mem[cpu_addr]; ack_rd = 1; ack_cyc = mcyc + 2;
        end
      end
      e_starve = waiting && (wcnt == MAXWAIT);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("sram_rd_n", 32'(o_SRAM_RD_n), 32'(e_rd_n));
      check("sram_wr_n", 32'(o_SRAM_WR_n), 32'(e_wr_n));
      if (!e_rd_n || !e_wr_n) check("sram_addr", 32'(o_SRAM_ADDR), 32'(e_addr));
      if (!e_wr_n) check("sram_din", 32'(o_SRAM_DIN), 32'(e_din));
      check("vid_valid", 32'(o_VID_VALID), 32'(e_vvalid));
      if (e_vvalid) check("vid_data", 32'(o_VID_DATA), 32'(e_vdata));
      check("cpu_ack", 32'(o_CPU_ACK), 32'(e_ack));
      check("cpu_dout", 32'(o_CPU_DOUT), 32'(e_dout));
      check("cpu_starve", 32'(o_CPU_STARVE), 32'(e_starve));
    end
  end

  // One CPU transaction with video held for the first nvid edges; k counts edges.
  task automatic cpu_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int nvid, input logic [AW-1:0] va,
                            output int k_issue, output int k_ack, output int k_starve,
                            output logic starve_after, output logic [AW-1:0] k0_addr,
                            output logic k0_rd_n, output logic [DW-1:0] dout);
    k_issue = -1; k_ack = -1; k_starve = -1; starve_after = 1'b1;
    k0_addr = '0; k0_rd_n = 1'b1; dout = '0;
    cpu_req = 1; cpu_wr = wr; cpu_addr = a; cpu_din = d;
    for (int k = 0; k < 30; k++) begin
      vid_req = (k < nvid); vid_addr = va;
      @(posedge clk); #1;
      if (k_ack >= 0) break;
      if (k == 0) begin k0_addr = o_SRAM_ADDR; k0_rd_n = o_SRAM_RD_n; end
      if (k_issue < 0 && o_SRAM_ADDR == a && (wr ? !o_SRAM_WR_n : !o_SRAM_RD_n)) begin
        k_issue = k; starve_after = o_CPU_STARVE;
      end
      if (k_starve < 0 && o_CPU_STARVE) k_starve = k;
      if (o_CPU_ACK) begin k_ack = k; dout = o_CPU_DOUT; cpu_req = 0; end
    end
    vid_req = 0; cpu_req = 0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] all1;
    all1 = '1;
    return ($urandom_range(0, 7) == 0) ? all1 : AW'($urandom_range(0, 15));
  endfunction

  initial begin
    int ki, ka, ks;
    logic sa, r0;
    logic [AW-1:0] a0;
    logic [DW-1:0] dv;
    logic vv [6];
    logic [DW-1:0] vd [6];
    bit got_ack, burst;

    #1 rst_n = 0;
    #1;
    check("rst_rd_n", 32'(o_SRAM_RD_n), 32'd1);
    check("rst_wr_n", 32'(o_SRAM_WR_n), 32'd1);
    check("rst_addr", 32'(o_SRAM_ADDR), 32'd0);
    check("rst_din", 32'(o_SRAM_DIN), 32'd0);
    check("rst_vid_data", 32'(o_VID_DATA), 32'd0);
    check("rst_cpu_dout", 32'(o_CPU_DOUT), 32'd0);
    check("rst_valid_ack_starve", 32'({o_VID_VALID, o_CPU_ACK, o_CPU_STARVE}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int k = 0; k < 6; k++) begin
      vid_req = (k < 4); vid_addr = AW'(16 + k);
      @(posedge clk); #1;
      vv[k] = o_VID_VALID; vd[k] = o_VID_DATA;
    end
    vid_req = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("vstream_valid_%0d", k), 32'(vv[k]), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) check($sformatf("vstream_data_%0d", k), 32'(vd[k]), 32'(8'hA0 + k - 2));
    end

    cpu_access(1'b1, 10'h3FF, 8'h5A, 0, 10'h000, ki, ka, ks, sa, a0, r0, dv);
    check("wr_issue_k", 32'(ki), 32'd0);
    check("wr_ack_k", 32'(ka), 32'd1);
    cpu_access(1'b0, 10'h3FF, 8'h00, 0, 10'h000, ki, ka, ks, sa, a0, r0, dv);
    check("rd_issue_k", 32'(ki), 32'd0);
    check("rd_ack_k", 32'(ka), 32'd2);
    check("rd_data", 32'(dv), 32'h5A);

    cpu_access(1'b0, 10'h3FF, 8'h00, 1, 10'h010, ki, ka, ks, sa, a0, r0, dv);
    check("coll_vid_first_rd_n", 32'(r0), 32'd0);
    check("coll_vid_first_addr", 32'(a0), 32'h010);
    check("coll_cpu_issue_k", 32'(ki), 32'd1);
    check("coll_ack_k", 32'(ka), 32'd3);
    check("coll_data", 32'(dv), 32'h5A);

    cpu_access(1'b0, 10'h3FF, 8'h00, 6, 10'h011, ki, ka, ks, sa, a0, r0, dv);
    check("starve_set_k", 32'(ks), 32'd4);
    check("starve_issue_k", 32'(ki), 32'd6);
    check("starve_clr_at_issue", 32'(sa), 32'd0);
    check("starve_ack_k", 32'(ka), 32'd8);

    cpu_req = 1; cpu_wr = 0; cpu_addr = 10'h3FF;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("rstmid_rd_n", 32'(o_SRAM_RD_n), 32'd1);
    check("rstmid_ack", 32'(o_CPU_ACK), 32'd0);
    check("rstmid_state", 32'(dut.cpu_state_q), 32'(C_IDLE));
    cpu_req = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_no_ack_%0d", k), 32'(o_CPU_ACK), 32'd0);
    end
    cpu_access(1'b0, 10'h3FF, 8'h00, 0, 10'h000, ki, ka, ks, sa, a0, r0, dv);
    check("post_rst_issue_k", 32'(ki), 32'd0);
    check("post_rst_data", 32'(dv), 32'h5A);

    cpu_access(1'b1, 10'h020, 8'h77, 10, 10'h012, ki, ka, ks, sa, a0, r0, dv);
    check("wbuf_wr_ack_k", 32'(ka), WRBUF ? 32'd1 : 32'd11);
    cpu_access(1'b0, 10'h020, 8'h00, 3, 10'h013, ki, ka, ks, sa, a0, r0, dv);
    check("wbuf_rd_issue_k", 32'(ki), WRBUF ? 32'd4 : 32'd3);
    check("wbuf_rd_data", 32'(dv), 32'h77);

    got_ack = 0; burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) burst = ($urandom_range(0, 1) == 1);
      vid_req = burst ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
      vid_addr = rnd_addr();
      if (cpu_req) begin
        if (got_ack) begin
          if ($urandom_range(0, 2) == 0) begin cpu_req = 0; got_ack = 0; end
        end else if ($urandom_range(0, 39) == 0) begin
          cpu_req = 0;
        end else if ($urandom_range(0, 4) == 0) begin
          cpu_wr = $urandom_range(0, 1) == 1; cpu_addr = rnd_addr(); cpu_din = DW'($urandom);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req = 1; got_ack = 0;
        cpu_wr = $urandom_range(0, 1) == 1; cpu_addr = rnd_addr(); cpu_din = DW'($urandom);
      end
      @(posedge clk); #1;
      if (o_CPU_ACK) got_ack = 1;
    end
    vid_req = 0; cpu_req = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
